// File: rtl/alu_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : alu_dispatch
//  Description : Initiator side of the ALU handshake for CHIP-8 8XYn
//                arithmetic. Accepts one request from decode, drives the ALU
//                through its reset / release / done sequence, then writes the
//                result to Vx and the carry flag to VF through a single
//                register-file write port. One operation in flight at a time.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT_CYCLES  : maximum number of WAIT cycles before the op is aborted
//    FLAG_REG        : register index that receives the carry flag
//  Ports
//    clk_in          : system clock
//    rst_in          : synchronous reset, active-high
//    start_in        : request strobe, sampled only while idle (busy_out = 0)
//    op_in           : low nibble n of 8XYn; only 4'h4 (ADD) is supported
//    x_in            : destination / first-operand register index
//    vx_in, vy_in    : operand values, valid with start_in
//    busy_out        : high from the cycle after accept until back in IDLE
//    done_out        : one-cycle pulse, both register writes have issued
//    error_out       : one-cycle pulse, unsupported op or ALU timeout
//    alu_rst_out     : ALU reset, high whenever the ALU is not in use
//    alu_in_out      : packed alu_input {op[19:16], operand_a[15:8],
//                      operand_b[7:0]}
//    alu_result_in   : ALU 8-bit result, valid only with alu_done_in
//    alu_overflow_in : ALU carry out, valid only with alu_done_in
//    alu_done_in     : ALU completion
//    wr_en_out       : register-file write enable
//    wr_addr_out     : register-file write index
//    wr_data_out     : register-file write data
// ============================================================================
module alu_dispatch #(
    parameter int         TIMEOUT_CYCLES = 16,
    parameter logic [3:0] FLAG_REG       = 4'hF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [3:0]  op_in,
    input  logic [3:0]  x_in,
    input  logic [7:0]  vx_in,
    input  logic [7:0]  vy_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        error_out,
    output logic        alu_rst_out,
    output logic [19:0] alu_in_out,
    input  logic [7:0]  alu_result_in,
    input  logic        alu_overflow_in,
    input  logic        alu_done_in,
    output logic        wr_en_out,
    output logic [3:0]  wr_addr_out,
    output logic [7:0]  wr_data_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // 8XY4 is the only arithmetic form this dispatcher forwards to the ALU.
    localparam logic [3:0]  c_NIBBLE_ADD  = 4'h4;
    // ALU-side opcode for addition carried in the alu_input struct.
    localparam logic [3:0]  c_ALU_OP_ADD  = 4'h4;
    localparam logic [19:0] c_ALU_IN_IDLE = {c_ALU_OP_ADD, 8'h00, 8'h00};

    // One spare bit so the counter can hold TIMEOUT_CYCLES without wrapping.
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_WB_X  = 3'd3;
    localparam logic [2:0] c_ST_WB_F  = 3'd4;
    localparam logic [2:0] c_ST_FIN   = 3'd5;
    localparam logic [2:0] c_ST_ERR   = 3'd6;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [3:0]         r_x;
    logic [19:0]        r_alu_in;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [7:0]         r_result;
    logic               r_carry;
    logic               w_accept_add;

    // A supported request accepted this cycle; launches the ALU sequence.
    assign w_accept_add = (r_state == c_ST_IDLE) && start_in &&
                          (op_in == c_NIBBLE_ADD);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start_in) begin
                    w_next_state = (op_in == c_NIBBLE_ADD) ? c_ST_ISSUE
                                                           : c_ST_ERR;
                end
            end
            c_ST_ISSUE: w_next_state = c_ST_WAIT;
            c_ST_WAIT: begin
                // Completion takes priority over an expiring timeout.
                if (alu_done_in) begin
                    w_next_state = c_ST_WB_X;
                end else if (r_wait_cnt == c_CNT_LAST) begin
                    w_next_state = c_ST_ERR;
                end
            end
            c_ST_WB_X:  w_next_state = c_ST_WB_F;
            c_ST_WB_F:  w_next_state = c_ST_FIN;
            c_ST_FIN:   w_next_state = c_ST_IDLE;
            c_ST_ERR:   w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand latch, timeout counter, result capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_x        <= 4'h0;
            r_alu_in   <= c_ALU_IN_IDLE;
            r_wait_cnt <= '0;
            r_result   <= 8'h00;
            r_carry    <= 1'b0;
        end else begin
            // Operands are loaded at accept so they are already on the ALU
            // inputs during ISSUE, while the ALU is still held in reset, and
            // stay put until the next accepted request. Rejected requests
            // leave the ALU inputs untouched.
            if (w_accept_add) begin
                r_x      <= x_in;
                r_alu_in <= {c_ALU_OP_ADD, vx_in, vy_in};
            end

            if (r_state == c_ST_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == c_ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            // ALU outputs may be undefined outside done, so they are only
            // sampled on the completion cycle inside WAIT.
            if ((r_state == c_ST_WAIT) && alu_done_in) begin
                r_result <= alu_result_in;
                r_carry  <= alu_overflow_in;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        busy_out    = 1'b0;
        done_out    = 1'b0;
        error_out   = 1'b0;
        alu_rst_out = 1'b1;
        wr_en_out   = 1'b0;
        wr_addr_out = 4'h0;
        wr_data_out = 8'h00;
        alu_in_out  = r_alu_in;

        if (rst_in) begin
            // Reset overrides the current state immediately so that a write
            // pending in this cycle is dropped rather than issued.
            alu_in_out = c_ALU_IN_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                end
                c_ST_ISSUE: begin
                    busy_out = 1'b1;
                end
                c_ST_WAIT: begin
                    busy_out    = 1'b1;
                    alu_rst_out = 1'b0;
                end
                c_ST_WB_X: begin
                    busy_out    = 1'b1;
                    wr_en_out   = 1'b1;
                    wr_addr_out = r_x;
                    wr_data_out = r_result;
                end
                c_ST_WB_F: begin
                    // Issued after the Vx write so that when x is the flag
                    // register the flag value is what remains.
                    busy_out    = 1'b1;
                    wr_en_out   = 1'b1;
                    wr_addr_out = FLAG_REG;
                    wr_data_out = {7'b0, r_carry};
                end
                c_ST_FIN: begin
                    busy_out = 1'b1;
                    done_out = 1'b1;
                end
                c_ST_ERR: begin
                    busy_out  = 1'b1;
                    error_out = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_dispatch
//  Description : Self-checking bench for alu_dispatch. A small ALU model
//                answers the handshake after a programmable delay; a monitor
//                logs register writes, pulses and release cycles; each
//                operation is compared against expectations from a table or
//                from a plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_dispatch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        start_in;
    logic [3:0]  op_in;
    logic [3:0]  x_in;
    logic [7:0]  vx_in;
    logic [7:0]  vy_in;
    logic        busy_out;
    logic        done_out;
    logic        error_out;
    logic        alu_rst_out;
    logic [19:0] alu_in_out;
    logic [7:0]  alu_result_in;
    logic        alu_overflow_in;
    logic        alu_done_in;
    logic        wr_en_out;
    logic [3:0]  wr_addr_out;
    logic [7:0]  wr_data_out;

    always #5 clk_in = ~clk_in;

    alu_dispatch #(
        .TIMEOUT_CYCLES(16),
        .FLAG_REG      (4'hF)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .op_in          (op_in),
        .x_in           (x_in),
        .vx_in          (vx_in),
        .vy_in          (vy_in),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .error_out      (error_out),
        .alu_rst_out    (alu_rst_out),
        .alu_in_out     (alu_in_out),
        .alu_result_in  (alu_result_in),
        .alu_overflow_in(alu_overflow_in),
        .alu_done_in    (alu_done_in),
        .wr_en_out      (wr_en_out),
        .wr_addr_out    (wr_addr_out),
        .wr_data_out    (wr_data_out)
    );

    // ------------------------------------------------------------------------
    // ALU model: counts cycles since release, raises done after alu_delay
    // cycles (0 = never). Result/carry are junk except on the done cycle.
    // ------------------------------------------------------------------------
    int         alu_delay  = 0;
    logic       force_done = 1'b0;
    int         alu_cnt    = 0;
    logic [7:0] junk_res   = 8'h00;
    logic       junk_c     = 1'b0;
    logic [8:0] alu_sum;

    always @(posedge clk_in) begin
        if (alu_rst_out) alu_cnt <= 0;
        else             alu_cnt <= alu_cnt + 1;
        junk_res <= 8'($urandom);
        junk_c   <= 1'($urandom);
    end

    assign alu_sum         = {1'b0, alu_in_out[15:8]} + {1'b0, alu_in_out[7:0]};
    assign alu_done_in     = force_done |
                             (!alu_rst_out && alu_delay != 0 && alu_cnt == alu_delay - 1);
    assign alu_result_in   = alu_done_in ? alu_sum[7:0] : junk_res;
    assign alu_overflow_in = alu_done_in ? alu_sum[8]   : junk_c;

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    int         cyc = 0;
    int         wr_cyc_q[$];
    logic [3:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         done_q[$];
    int         err_q[$];
    int         rel_q[$];
    logic [7:0] regs [16];

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (wr_en_out) begin
            wr_cyc_q.push_back(cyc);
            wr_addr_q.push_back(wr_addr_out);
            wr_data_q.push_back(wr_data_out);
            regs[wr_addr_out] = wr_data_out;
        end
        if (done_out)     done_q.push_back(cyc);
        if (error_out)    err_q.push_back(cyc);
        if (!alu_rst_out) rel_q.push_back(cyc);
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one request and checks it. Timing is relative to the cycle t0 in
    // which start_in is presented: ISSUE at t0+1, WAIT from t0+2, done seen
    // at t0+1+d, Vx write t0+2+d, VF write t0+3+d, done_out t0+4+d.
    task automatic run_op(input logic [3:0] op, input logic [3:0] x,
                          input logic [7:0] vx, input logic [7:0] vy, input int d,
                          input logic exp_err, input logic [7:0] exp_res,
                          input logic exp_flag);
        int          t0, bw, bd, be, br;
        logic [19:0] issue_in;
        logic        busy1;
        bit          ended;
        bit          unsup;
        unsup     = (op != 4'h4);
        alu_delay = d;
        bw = wr_cyc_q.size(); bd = done_q.size(); be = err_q.size(); br = rel_q.size();
        @(posedge clk_in); #1;
        start_in = 1'b1; op_in = op; x_in = x; vx_in = vx; vy_in = vy;
        t0 = cyc;
        @(posedge clk_in); #1;
        start_in = 1'b0; vx_in = 8'($urandom); vy_in = 8'($urandom); x_in = 4'($urandom);
        @(negedge clk_in);
        issue_in = alu_in_out;
        busy1    = busy_out;
        ended    = 1'b0;
        for (int i = 0; i < 40 && !ended; i++) begin
            @(negedge clk_in);
            if (done_q.size() > bd || err_q.size() > be) ended = 1'b1;
        end
        repeat (3) @(negedge clk_in);

        chk("op_complete", 32'(ended), 1);
        chk("busy_after_accept", 32'(busy1), 1);
        if (exp_err) begin
            chk("err_count", err_q.size() - be, 1);
            if (err_q.size() > be) chk("err_cycle", err_q[be] - t0, unsup ? 1 : 18);
            chk("wr_count_err", wr_cyc_q.size() - bw, 0);
            chk("done_count_err", done_q.size() - bd, 0);
            chk("release_cycles_err", rel_q.size() - br, unsup ? 0 : 16);
            if (!unsup) chk("alu_in_issue", 32'(issue_in), 32'({4'h4, vx, vy}));
        end else begin
            chk("alu_in_issue", 32'(issue_in), 32'({4'h4, vx, vy}));
            chk("done_count", done_q.size() - bd, 1);
            if (done_q.size() > bd) chk("done_cycle", done_q[bd] - t0, 4 + d);
            chk("err_count_ok", err_q.size() - be, 0);
            chk("release_cycles", rel_q.size() - br, d);
            chk("wr_count", wr_cyc_q.size() - bw, 2);
            if (wr_cyc_q.size() - bw == 2) begin
                chk("wr0_addr",  32'(wr_addr_q[bw]), 32'(x));
                chk("wr0_data",  32'(wr_data_q[bw]), 32'(exp_res));
                chk("wr0_cycle", wr_cyc_q[bw] - t0, 2 + d);
                chk("wr1_addr",  32'(wr_addr_q[bw+1]), 32'hF);
                chk("wr1_data",  32'(wr_data_q[bw+1]), 32'(exp_flag));
                chk("wr1_cycle", wr_cyc_q[bw+1] - t0, 3 + d);
                chk("reg_x_final", 32'(regs[x]),
                    (x == 4'hF) ? 32'(exp_flag) : 32'(exp_res));
                chk("reg_f_final", 32'(regs[15]), 32'(exp_flag));
            end
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [3:0] x;
        logic [7:0] vx;
        logic [7:0] vy;
        int         d;
        logic       exp_err;
        logic [7:0] exp_res;
        logic       exp_flag;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          bw, bd, be, t0;
        logic [3:0]  r_op, r_x;
        logic [7:0]  r_vx, r_vy;
        int          r_d, sum;
        logic        r_err;

        tbl[0] = '{4'h4, 4'h2, 8'hF0, 8'h20, 3,  1'b0, 8'h10, 1'b1};
        tbl[1] = '{4'h4, 4'h5, 8'h12, 8'h34, 1,  1'b0, 8'h46, 1'b0};
        tbl[2] = '{4'h4, 4'hF, 8'hFF, 8'h01, 2,  1'b0, 8'h00, 1'b1};
        tbl[3] = '{4'h7, 4'h3, 8'h11, 8'h22, 3,  1'b1, 8'h00, 1'b0};
        tbl[4] = '{4'h4, 4'h7, 8'h80, 8'h80, 16, 1'b0, 8'h00, 1'b1};
        tbl[5] = '{4'h4, 4'h9, 8'hAA, 8'hBB, 0,  1'b1, 8'h00, 1'b0};
        tbl[6] = '{4'h4, 4'h0, 8'h00, 8'h00, 1,  1'b0, 8'h00, 1'b0};
        tbl[7] = '{4'h0, 4'h1, 8'h55, 8'h55, 2,  1'b1, 8'h00, 1'b0};
        tbl[8] = '{4'h4, 4'h1, 8'h7F, 8'h01, 5,  1'b0, 8'h80, 1'b0};
        tbl[9] = '{4'h4, 4'hE, 8'hC8, 8'h64, 4,  1'b0, 8'h2C, 1'b1};

        rst_in = 1'b1; start_in = 1'b0; op_in = 4'h0; x_in = 4'h0;
        vx_in = 8'h00; vy_in = 8'h00;

        // Reset state
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_busy",    32'(busy_out), 0);
        chk("rst_alu_rst", 32'(alu_rst_out), 1);
        chk("rst_done",    32'(done_out), 0);
        chk("rst_error",   32'(error_out), 0);
        chk("rst_wr_en",   32'(wr_en_out), 0);
        chk("rst_wr_addr", 32'(wr_addr_out), 0);
        chk("rst_wr_data", 32'(wr_data_out), 0);
        chk("rst_alu_in",  32'(alu_in_out), 32'h40000);
        @(posedge clk_in); #1 rst_in = 1'b0;
        @(negedge clk_in);
        chk("idle_busy", 32'(busy_out), 0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, tbl[i].x, tbl[i].vx, tbl[i].vy, tbl[i].d,
                   tbl[i].exp_err, tbl[i].exp_res, tbl[i].exp_flag);
        end

        // start_in while busy is neither accepted nor queued
        alu_delay = 3;
        bw = wr_cyc_q.size(); bd = done_q.size(); be = err_q.size();
        @(posedge clk_in); #1;
        start_in = 1'b1; op_in = 4'h4; x_in = 4'h2; vx_in = 8'h01; vy_in = 8'h02;
        t0 = cyc;
        @(posedge clk_in); #1 start_in = 1'b0;
        @(posedge clk_in); #1;
        start_in = 1'b1; x_in = 4'h8; vx_in = 8'h55; vy_in = 8'h66;
        @(posedge clk_in); #1 start_in = 1'b0;
        @(negedge clk_in);
        chk("busy_alu_in_hold", 32'(alu_in_out), 32'h40102);
        repeat (14) @(negedge clk_in);
        chk("busy_wr_count", wr_cyc_q.size() - bw, 2);
        if (wr_cyc_q.size() > bw) begin
            chk("busy_wr0_addr", 32'(wr_addr_q[bw]), 2);
            chk("busy_wr0_data", 32'(wr_data_q[bw]), 3);
        end
        chk("busy_done_count", done_q.size() - bd, 1);
        if (done_q.size() > bd) chk("busy_done_cycle", done_q[bd] - t0, 7);
        chk("busy_err_count", err_q.size() - be, 0);

        // Reset during WAIT
        alu_delay = 0;
        @(posedge clk_in); #1;
        start_in = 1'b1; op_in = 4'h4; x_in = 4'h3; vx_in = 8'h01; vy_in = 8'h02;
        @(posedge clk_in); #1 start_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        chk("mid_in_wait", 32'(alu_rst_out), 0);
        bw = wr_cyc_q.size(); bd = done_q.size(); be = err_q.size();
        @(posedge clk_in); #1 rst_in = 1'b1;
        @(negedge clk_in);
        chk("mid_rst_alu_rst", 32'(alu_rst_out), 1);
        chk("mid_rst_wr_en",   32'(wr_en_out), 0);
        chk("mid_rst_busy",    32'(busy_out), 0);
        chk("mid_rst_alu_in",  32'(alu_in_out), 32'h40000);
        @(posedge clk_in); #1 rst_in = 1'b0;
        @(negedge clk_in);
        chk("post_rst_busy",    32'(busy_out), 0);
        chk("post_rst_alu_rst", 32'(alu_rst_out), 1);
        repeat (20) @(negedge clk_in);
        chk("post_rst_writes", wr_cyc_q.size() - bw, 0);
        chk("post_rst_events", (done_q.size() - bd) + (err_q.size() - be), 0);
        run_op(4'h4, 4'h6, 8'h30, 8'h0F, 2, 1'b0, 8'h3F, 1'b0);

        // alu_done_in outside WAIT has no effect
        bw = wr_cyc_q.size(); bd = done_q.size();
        @(posedge clk_in); #1 force_done = 1'b1;
        repeat (4) @(negedge clk_in);
        @(posedge clk_in); #1 force_done = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("stray_done_writes", wr_cyc_q.size() - bw, 0);
        chk("stray_done_pulses", done_q.size() - bd, 0);
        chk("stray_done_busy",   32'(busy_out), 0);

        // Randomized requests against the arithmetic reference model
        for (int n = 0; n < 30; n++) begin
            r_op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h4;
            r_x  = 4'($urandom);
            r_vx = 8'($urandom);
            r_vy = 8'($urandom);
            r_d  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16));
            sum  = int'(r_vx) + int'(r_vy);
            r_err = (r_op != 4'h4) || (r_d == 0);
            run_op(r_op, r_x, r_vx, r_vy, r_d, r_err, 8'(sum % 256), (sum > 255));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
